testeio_param_out: RTL and testbench

Avalon-MM write-side parameter port for the `testeio` Qsys system, the output-direction counterpart of the 32-bit input PIO slaves. The Nios II writes a 32-bit value into a shadow register, then issues a commit. The block presents the value on `out_port` with a valid/ready handshake to the genetic-circuit datapath, queues one further commit while busy, and exposes status for polling.

---
 rtl/testeio_param_out_pkg.sv | 25 ++
 rtl/testeio_param_out_hs.sv | 86 ++++++++
 rtl/testeio_param_out.sv | 91 +++++++++
 tb/tb_testeio_param_out.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/testeio_param_out_pkg.sv
// Shared constants and types for the testeio parameter output port:
// register map, status bit positions and the handshake FSM encoding.
package testeio_param_out_pkg;

    // Avalon-MM word addresses on the s1 slave
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_SET  = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    // Bit positions inside the STATUS word
    localparam int ST_BUSY     = 0;
    localparam int ST_PENDING  = 1;
    localparam int ST_OVERFLOW = 2;

    // CTRL write with this bit set clears overflow instead of committing
    localparam int CTRL_CLR_OVF_BIT = 31;

    // Output handshake FSM
    typedef enum logic {
        HS_IDLE  = 1'b0,
        HS_VALID = 1'b1
    } hs_state_t;

endpackage

// File: rtl/testeio_param_out_hs.sv
// Valid/ready handshake for the committed parameter value. Holds out_port,
// one queued commit (pending) and a sticky overflow flag for commits that
// arrive while a commit is already queued.
module testeio_param_out_hs
    import testeio_param_out_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit,
    input  logic                  clr_ovf,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] shadow,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    output logic                  pending,
    output logic                  overflow
);

    hs_state_t state_q;
    hs_state_t state_d;
    logic      transfer;
    logic      load_port;
    logic      pending_d;
    logic      overflow_d;

    assign transfer = (state_q == HS_VALID) && out_ready;

    // State register
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= HS_IDLE;
        else       state_q <= state_d;
    end

    // Next state: leave VALID only when the value is taken and nothing follows it
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HS_IDLE:  if (commit) state_d = HS_VALID;
            HS_VALID: if (transfer && !pending && !commit) state_d = HS_IDLE;
            default:  state_d = HS_IDLE;
        endcase
    end

    // Outputs and register updates: reload decision, pending queue, overflow
    always_comb begin
        out_valid  = (state_q == HS_VALID);
        load_port  = 1'b0;
        pending_d  = pending;
        overflow_d = overflow;
        if (clr_ovf) overflow_d = 1'b0;
        case (state_q)
            HS_IDLE: load_port = commit;
            HS_VALID: begin
                if (transfer) begin
                    // A queued or coincident commit refills the port at once
                    load_port = pending || commit;
                    pending_d = pending && commit;
                end else if (commit) begin
                    if (pending) overflow_d = 1'b1;
                    else         pending_d  = 1'b1;
                end
            end
            default: load_port = 1'b0;
        endcase
    end

    // Data path registers; the reload sees the shadow value from before this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load_port) out_port <= shadow;
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: rtl/testeio_param_out.sv
// testeio parameter output port: Avalon-MM s1 slave with a shadow register,
// commit/status control and a valid/ready output handshake.
// Build option: define TESTEIO_PARAM_OUT_BITOPS_EN to enable atomic
// set (address 2) and clear (address 3) on the shadow register.
module testeio_param_out
    import testeio_param_out_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ctrl_wr;
    logic                  commit;
    logic                  clr_ovf;
    logic                  pending;
    logic                  overflow;
    logic [31:0]           rd_d;

    // Upper writedata bits beyond the shadow width are simply dropped
    assign wdata   = writedata[DATA_WIDTH-1:0];
    assign ctrl_wr = write && (address == ADDR_CTRL);
    assign commit  = ctrl_wr && !writedata[CTRL_CLR_OVF_BIT];
    assign clr_ovf = ctrl_wr &&  writedata[CTRL_CLR_OVF_BIT];

    // Shadow register: loaded by DATA writes, optionally set/cleared bitwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (write) begin
            case (address)
                ADDR_DATA: shadow_q <= wdata;
`ifdef TESTEIO_PARAM_OUT_BITOPS_EN
                ADDR_SET:  shadow_q <= shadow_q | wdata;
                ADDR_CLR:  shadow_q <= shadow_q & ~wdata;
`endif
                default:   shadow_q <= shadow_q;
            endcase
        end
    end

    testeio_param_out_hs #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hs (
        .clk       (clk),
        .reset     (reset),
        .commit    (commit),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .shadow    (shadow_q),
        .out_port  (out_port),
        .out_valid (out_valid),
        .pending   (pending),
        .overflow  (overflow)
    );

    // Read mux: zero-extended shadow or status word, 0 for unmapped addresses
    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA: rd_d[DATA_WIDTH-1:0] = shadow_q;
            ADDR_CTRL: begin
                rd_d[ST_BUSY]     = out_valid;
                rd_d[ST_PENDING]  = pending;
                rd_d[ST_OVERFLOW] = overflow;
            end
`ifdef TESTEIO_PARAM_OUT_BITOPS_EN
            ADDR_SET:  rd_d[DATA_WIDTH-1:0] = shadow_q;
            ADDR_CLR:  rd_d[DATA_WIDTH-1:0] = shadow_q;
`endif
            default:   rd_d = '0;
        endcase
    end

    // Read data registered every cycle, giving one cycle of read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_d;
    end

endmodule

// File: tb/tb_testeio_param_out.sv
// Directed self-checking bench for testeio_param_out. Inputs change 1 ns
// after the rising edge and outputs are sampled there as well.
module tb_testeio_param_out;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd;

    always #5 clk = ~clk;

    testeio_param_out #(
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        write   = 1'b0;
        tick();
        d = readdata;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_port", out_port, 0);
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            check($sformatf("rst_read%0d", a), rd, 0);
        end

        // ---------------- basic commit, stalled then accepted ----------------
        bus_write(2'd0, 32'hDEADBEEF);
        bus_write(2'd1, 32'h0);
        check("c1_valid", out_valid, 1);
        check("c1_port", out_port, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            bus_read(2'd1, rd);
            check($sformatf("c1_status_busy%0d", i), rd, 32'h1);
            check($sformatf("c1_hold_valid%0d", i), out_valid, 1);
            check($sformatf("c1_hold_port%0d", i), out_port, 32'hDEADBEEF);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("c1_done_valid", out_valid, 0);
        check("c1_done_port", out_port, 32'hDEADBEEF);
        bus_read(2'd1, rd);
        check("c1_status_idle", rd, 32'h0);

        // ---------------- pending, overflow, clear, back-to-back ----------------
        bus_write(2'd0, 32'h11111111);
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h22222222);
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h33333333);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, rd);
        check("ovf_status", rd, 32'h7);
        check("ovf_port_stable", out_port, 32'h11111111);
        bus_write(2'd1, 32'h80000000);
        bus_read(2'd1, rd);
        check("ovf_cleared", rd, 32'h3);
        // Transfer with pending while DATA is rewritten: reload gets old shadow
        out_ready = 1'b1;
        bus_write(2'd0, 32'h44444444);
        check("b2b_valid1", out_valid, 1);
        check("b2b_port1", out_port, 32'h33333333);
        tick();
        out_ready = 1'b0;
        check("b2b_valid2", out_valid, 0);
        check("b2b_port2", out_port, 32'h33333333);
        bus_read(2'd0, rd);
        check("b2b_shadow", rd, 32'h44444444);

        // ---------------- commit coincident with transfer, pending=0 ----------------
        bus_write(2'd0, 32'hAAAA5555);
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h12345678);
        out_ready = 1'b1;
        bus_write(2'd1, 32'h0);
        check("coinc_valid", out_valid, 1);
        check("coinc_port", out_port, 32'h12345678);
        bus_read(2'd1, rd);
        check("coinc_status", rd, 32'h1);
        check("coinc_drained", out_valid, 0);
        out_ready = 1'b0;

        // ---------------- commit coincident with transfer, pending=1 ----------------
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h0BADF00D);
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h0000C0DE);
        out_ready = 1'b1;
        bus_write(2'd1, 32'h0);
        out_ready = 1'b0;
        check("coincp_port", out_port, 32'h0000C0DE);
        bus_read(2'd1, rd);
        check("coincp_status", rd, 32'h3);
        out_ready = 1'b1;
        tick();
        check("coincp_still_valid", out_valid, 1);
        tick();
        out_ready = 1'b0;
        check("coincp_drained", out_valid, 0);

        // ---------------- set / clear on the shadow ----------------
        bus_write(2'd0, 32'h0F0F0000);
        bus_write(2'd2, 32'h000000FF);
        bus_write(2'd3, 32'h0F000000);
        bus_read(2'd0, rd);
`ifdef TESTEIO_PARAM_OUT_BITOPS_EN
        check("bitops_data", rd, 32'h000F00FF);
        bus_read(2'd2, rd);
        check("bitops_rd2", rd, 32'h000F00FF);
        bus_read(2'd3, rd);
        check("bitops_rd3", rd, 32'h000F00FF);
`else
        check("bitops_data", rd, 32'h0F0F0000);
        bus_read(2'd2, rd);
        check("bitops_rd2", rd, 32'h0);
        bus_read(2'd3, rd);
        check("bitops_rd3", rd, 32'h0);
`endif
        check("bitops_no_port_change", out_port, 32'h0000C0DE);

        // ---------------- async reset mid-VALID with pending ----------------
        bus_write(2'd1, 32'h0);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, rd);
        check("prerst_status", rd, 32'h3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_port", out_port, 0);
        check("arst_readdata", readdata, 0);
        tick();
        reset = 1'b0;
        bus_read(2'd1, rd);
        check("postrst_status", rd, 32'h0);
        bus_read(2'd0, rd);
        check("postrst_shadow", rd, 32'h0);
        bus_write(2'd0, 32'h5A5A5A5A);
        bus_write(2'd1, 32'h0);
        check("postrst_valid", out_valid, 1);
        check("postrst_port", out_port, 32'h5A5A5A5A);
        out_ready = 1'b1;
        tick();
        check("postrst_xfer", out_valid, 0);
        tick();
        check("postrst_once", out_valid, 0);
        out_ready = 1'b0;
        bus_read(2'd1, rd);
        check("postrst_final_status", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
